// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: takes one AC snoop at a time, looks the line up in the
// L1, applies the coherency state change and answers on CR (plus CD data).
module ace_snoop_responder #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned LineWidth = 512
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ac_valid_i,
    output logic                 ac_ready_o,
    input  logic [AddrWidth-1:0] ac_addr_i,
    input  logic [3:0]           ac_snoop_i,
    output logic                 cr_valid_o,
    input  logic                 cr_ready_i,
    output logic [4:0]           cr_resp_o,
    output logic                 cd_valid_o,
    input  logic                 cd_ready_i,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,
    output logic                 lookup_req_o,
    output logic [AddrWidth-1:0] lookup_addr_o,
    input  logic                 lookup_gnt_i,
    input  logic                 lookup_valid_i,
    input  logic                 lookup_hit_i,
    input  logic                 lookup_dirty_i,
    input  logic                 lookup_shared_i,
    input  logic [LineWidth-1:0] lookup_data_i,
    output logic                 update_req_o,
    output logic                 update_inval_o,
    input  logic                 update_gnt_i,
    output logic                 unsupported_o
);

    localparam int unsigned Beats = LineWidth / DataWidth;
    localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned OffW  = $clog2(LineWidth / 8);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
    localparam logic SingleBeat = (Beats == 1);

    localparam logic [3:0] SnpReadOnce     = 4'b0000;
    localparam logic [3:0] SnpReadShared   = 4'b0001;
    localparam logic [3:0] SnpReadClean    = 4'b0010;
    localparam logic [3:0] SnpReadNsd      = 4'b0011;
    localparam logic [3:0] SnpReadUnique   = 4'b0111;
    localparam logic [3:0] SnpCleanShared  = 4'b1000;
    localparam logic [3:0] SnpCleanInvalid = 4'b1001;
    localparam logic [3:0] SnpMakeInvalid  = 4'b1101;

    typedef enum logic [2:0] {StIdle, StLookup, StWait, StUpdate, StResp} state_e;

    state_e               r_state;
    logic                 r_ac_ready;
    logic [3:0]           r_snoop;
    logic [AddrWidth-1:0] r_lookup_addr;
    logic                 r_lookup_req;
    logic                 r_update_req;
    logic                 r_update_inval;
    logic                 r_cr_valid;
    logic [4:0]           r_cr_resp;
    logic                 r_cd_valid;
    logic                 r_cd_last;
    logic [BeatW-1:0]     r_beat;
    logic [LineWidth-1:0] r_line;
    logic                 r_unsupported;

    logic       w_supported;
    logic       w_was_unique;
    logic [4:0] w_resp;
    logic       w_upd;
    logic       w_inval;
    logic       w_result;
    logic       w_cr_done;
    logic       w_cd_done;
    logic       w_unused_addr;

    // Offset bits are dropped: lookups are always line aligned.
    assign w_unused_addr = ^ac_addr_i[OffW-1:0];

    assign w_was_unique = ~lookup_shared_i;
    // Lookup result arrives either in WAIT or together with the grant.
    assign w_result  = lookup_valid_i &&
                       ((r_state == StLookup && lookup_gnt_i) || r_state == StWait);
    // A channel is finished once its valid has dropped or is being accepted now.
    assign w_cr_done = !r_cr_valid || cr_ready_i;
    assign w_cd_done = !r_cd_valid || (cd_ready_i && r_cd_last);

    // Classify the incoming snoop type.
    always_comb begin
        w_supported = 1'b0;
        case (ac_snoop_i)
            SnpReadOnce, SnpReadShared, SnpReadClean, SnpReadNsd, SnpReadUnique,
            SnpCleanShared, SnpCleanInvalid, SnpMakeInvalid: w_supported = 1'b1;
            default: w_supported = 1'b0;
        endcase
    end

    // CR bits {WasUnique, IsShared, PassDirty, Error, DataTransfer} and update decision.
    always_comb begin
        w_resp  = 5'b0;
        w_upd   = 1'b0;
        w_inval = 1'b0;
        if (lookup_hit_i) begin
            case (r_snoop)
                SnpReadOnce: begin
                    w_resp = {w_was_unique, 1'b1, 1'b0, 1'b0, 1'b1};
                end
                SnpReadShared, SnpReadClean, SnpReadNsd: begin
                    w_resp = {w_was_unique, 1'b1, lookup_dirty_i, 1'b0, 1'b1};
                    w_upd  = 1'b1;
                end
                SnpReadUnique: begin
                    w_resp  = {w_was_unique, 1'b0, lookup_dirty_i, 1'b0, 1'b1};
                    w_upd   = 1'b1;
                    w_inval = 1'b1;
                end
                SnpCleanInvalid: begin
                    w_resp  = {w_was_unique, 1'b0, lookup_dirty_i, 1'b0, lookup_dirty_i};
                    w_upd   = 1'b1;
                    w_inval = 1'b1;
                end
                SnpCleanShared: begin
                    w_resp = {w_was_unique, 1'b1, lookup_dirty_i, 1'b0, lookup_dirty_i};
                    w_upd  = lookup_dirty_i;
                end
                SnpMakeInvalid: begin
                    w_resp  = {w_was_unique, 4'b0};
                    w_upd   = 1'b1;
                    w_inval = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Main FSM; all interface outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= StIdle;
            r_ac_ready     <= 1'b0;
            r_snoop        <= 4'b0;
            r_lookup_addr  <= '0;
            r_lookup_req   <= 1'b0;
            r_update_req   <= 1'b0;
            r_update_inval <= 1'b0;
            r_cr_valid     <= 1'b0;
            r_cr_resp      <= 5'b0;
            r_cd_valid     <= 1'b0;
            r_cd_last      <= 1'b0;
            r_beat         <= '0;
            r_line         <= '0;
            r_unsupported  <= 1'b0;
        end else begin
            r_unsupported <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_ac_ready <= 1'b1;
                    if (ac_valid_i && r_ac_ready) begin
                        r_ac_ready    <= 1'b0;
                        r_snoop       <= ac_snoop_i;
                        r_lookup_addr <= {ac_addr_i[AddrWidth-1:OffW], {OffW{1'b0}}};
                        if (w_supported) begin
                            r_lookup_req <= 1'b1;
                            r_state      <= StLookup;
                        end else begin
                            // Unsupported: answer with an empty CR, no lookup.
                            r_unsupported <= 1'b1;
                            r_cr_resp     <= 5'b0;
                            r_cr_valid    <= 1'b1;
                            r_cd_valid    <= 1'b0;
                            r_cd_last     <= 1'b0;
                            r_beat        <= '0;
                            r_state       <= StResp;
                        end
                    end
                end
                StLookup, StWait: begin
                    if (r_state == StLookup && lookup_gnt_i) begin
                        r_lookup_req <= 1'b0;
                        r_state      <= StWait;
                    end
                    if (w_result) begin
                        r_line    <= lookup_data_i;
                        r_cr_resp <= w_resp;
                        if (w_upd) begin
                            r_update_req   <= 1'b1;
                            r_update_inval <= w_inval;
                            r_state        <= StUpdate;
                        end else begin
                            r_cr_valid <= 1'b1;
                            r_cd_valid <= w_resp[0];
                            r_cd_last  <= w_resp[0] && SingleBeat;
                            r_beat     <= '0;
                            r_state    <= StResp;
                        end
                    end
                end
                StUpdate: begin
                    if (update_gnt_i) begin
                        r_update_req   <= 1'b0;
                        r_update_inval <= 1'b0;
                        r_cr_valid     <= 1'b1;
                        r_cd_valid     <= r_cr_resp[0];
                        r_cd_last      <= r_cr_resp[0] && SingleBeat;
                        r_beat         <= '0;
                        r_state        <= StResp;
                    end
                end
                StResp: begin
                    if (r_cr_valid && cr_ready_i) begin
                        r_cr_valid <= 1'b0;
                    end
                    if (r_cd_valid && cd_ready_i) begin
                        if (r_cd_last) begin
                            r_cd_valid <= 1'b0;
                            r_cd_last  <= 1'b0;
                        end else begin
                            // Shift the next beat into the low slice driving cd_data_o.
                            r_beat    <= r_beat + BeatW'(1);
                            r_line    <= r_line >> DataWidth;
                            r_cd_last <= (r_beat + BeatW'(1)) == LastBeat;
                        end
                    end
                    if (w_cr_done && w_cd_done) begin
                        r_cr_resp  <= 5'b0;
                        r_ac_ready <= 1'b1;
                        r_state    <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign ac_ready_o     = r_ac_ready;
    assign lookup_req_o   = r_lookup_req;
    assign lookup_addr_o  = r_lookup_addr;
    assign update_req_o   = r_update_req;
    assign update_inval_o = r_update_inval;
    assign cr_valid_o     = r_cr_valid;
    assign cr_resp_o      = r_cr_resp;
    assign cd_valid_o     = r_cd_valid;
    assign cd_last_o      = r_cd_last;
    assign cd_data_o      = r_line[DataWidth-1:0];
    assign unsupported_o  = r_unsupported;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder: vector table plus stall, same-cycle
// grant/result and mid-transaction reset sequences.
module tb_ace_snoop_responder;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LW = 512;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          ac_valid_i;
    logic          ac_ready_o;
    logic [AW-1:0] ac_addr_i;
    logic [3:0]    ac_snoop_i;
    logic          cr_valid_o;
    logic          cr_ready_i;
    logic [4:0]    cr_resp_o;
    logic          cd_valid_o;
    logic          cd_ready_i;
    logic [DW-1:0] cd_data_o;
    logic          cd_last_o;
    logic          lookup_req_o;
    logic [AW-1:0] lookup_addr_o;
    logic          lookup_gnt_i;
    logic          lookup_valid_i;
    logic          lookup_hit_i;
    logic          lookup_dirty_i;
    logic          lookup_shared_i;
    logic [LW-1:0] lookup_data_i;
    logic          update_req_o;
    logic          update_inval_o;
    logic          update_gnt_i;
    logic          unsupported_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    ace_snoop_responder #(
        .AddrWidth(AW),
        .DataWidth(DW),
        .LineWidth(LW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .ac_valid_i     (ac_valid_i),
        .ac_ready_o     (ac_ready_o),
        .ac_addr_i      (ac_addr_i),
        .ac_snoop_i     (ac_snoop_i),
        .cr_valid_o     (cr_valid_o),
        .cr_ready_i     (cr_ready_i),
        .cr_resp_o      (cr_resp_o),
        .cd_valid_o     (cd_valid_o),
        .cd_ready_i     (cd_ready_i),
        .cd_data_o      (cd_data_o),
        .cd_last_o      (cd_last_o),
        .lookup_req_o   (lookup_req_o),
        .lookup_addr_o  (lookup_addr_o),
        .lookup_gnt_i   (lookup_gnt_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_hit_i   (lookup_hit_i),
        .lookup_dirty_i (lookup_dirty_i),
        .lookup_shared_i(lookup_shared_i),
        .lookup_data_i  (lookup_data_i),
        .update_req_o   (update_req_o),
        .update_inval_o (update_inval_o),
        .update_gnt_i   (update_gnt_i),
        .unsupported_o  (unsupported_o)
    );

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  snoop;
        logic        hit;
        logic        dirty;
        logic        shared;
        logic [63:0] base;
        logic [4:0]  exp_resp;
        logic        exp_upd;
        logic        exp_inval;
        int          exp_beats;
        logic        exp_unsup;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctrl outputs"}, 64'({ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o,
              cd_last_o, lookup_req_o, update_req_o, update_inval_o, unsupported_o}), 64'd0);
        check({tag, " cd_data"}, cd_data_o, 64'd0);
        check({tag, " lookup_addr"}, lookup_addr_o, 64'd0);
    endtask

    // Issue one snoop (called at a negedge while idle), act as the cache and the
    // interconnect, and compare everything observed against the vector.
    task automatic run_txn(input string tag, input vec_t v, input int cr_hold,
                           input bit cd_toggle, input bit same_cycle, input int abort_at);
        logic [LW-1:0] line;
        logic [63:0]   lk_addr = '0;
        logic [63:0]   prev_data = '0;
        logic [4:0]    resp_seen = '0;
        logic          inval_seen = 1'b0;
        logic          lk_seen = 1'b0;
        logic          prev_stall = 1'b0;
        bit            done = 1'b0;
        bit            aborted = 1'b0;
        int phase = 0;
        int cr_wait = 0;
        int cr_acc = 0;
        int beats = 0;
        int upd_cnt = 0;
        int unsup_cnt = 0;
        int lat = -1;
        int exp_lat;

        for (int k = 0; k < 8; k++) line[k*64 +: 64] = v.base + 64'(k);
        exp_lat = v.exp_unsup ? 1 : ((same_cycle ? 2 : 3) + int'(v.exp_upd));

        check({tag, " ac_ready idle"}, 64'(ac_ready_o), 64'd1);
        ac_valid_i = 1'b1;
        ac_addr_i  = v.addr;
        ac_snoop_i = v.snoop;
        cd_ready_i = 1'b0;
        cr_ready_i = 1'b0;

        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk_i);
            ac_valid_i = 1'b0;
            if (ac_ready_o) begin
                done = 1'b1;
                break;
            end
            if (unsupported_o) unsup_cnt++;
            if (lookup_req_o && !lk_seen) begin
                lk_seen = 1'b1;
                lk_addr = lookup_addr_o;
            end
            // cache lookup port
            case (phase)
                0: if (lookup_req_o) begin
                    lookup_gnt_i = 1'b1;
                    phase = 1;
                    if (same_cycle) begin
                        lookup_valid_i  = 1'b1;
                        lookup_hit_i    = v.hit;
                        lookup_dirty_i  = v.dirty;
                        lookup_shared_i = v.shared;
                        lookup_data_i   = line;
                        phase = 2;
                    end
                end
                1: begin
                    lookup_gnt_i    = 1'b0;
                    lookup_valid_i  = 1'b1;
                    lookup_hit_i    = v.hit;
                    lookup_dirty_i  = v.dirty;
                    lookup_shared_i = v.shared;
                    lookup_data_i   = line;
                    phase = 2;
                end
                2: begin
                    lookup_gnt_i   = 1'b0;
                    lookup_valid_i = 1'b0;
                    phase = 3;
                end
                default: ;
            endcase
            // cache update port
            update_gnt_i = 1'b0;
            if (update_req_o) begin
                upd_cnt++;
                inval_seen   = update_inval_o;
                update_gnt_i = 1'b1;
            end
            // CR channel
            if (cr_valid_o && lat < 0) lat = cyc;
            cr_ready_i = 1'b0;
            if (cr_valid_o) begin
                if (cr_wait >= cr_hold) begin
                    cr_ready_i = 1'b1;
                    cr_acc++;
                    resp_seen = cr_resp_o;
                end else begin
                    cr_wait++;
                end
            end
            // CD channel
            if (abort_at >= 0 && cd_valid_o && beats == abort_at) begin
                rst_ni = 1'b0;
                #1;
                check_all_zero({tag, " abort"});
                aborted = 1'b1;
                break;
            end
            if (prev_stall) begin
                check({tag, " cd_data stable"}, cd_data_o, prev_data);
                check({tag, " cd_valid held"}, 64'(cd_valid_o), 64'd1);
            end
            cd_ready_i = cd_toggle ? !cd_ready_i : 1'b1;
            if (cd_valid_o && cd_ready_i) begin
                check($sformatf("%s cd_data beat%0d", tag, beats), cd_data_o,
                      v.base + 64'(beats));
                check($sformatf("%s cd_last beat%0d", tag, beats), 64'(cd_last_o),
                      64'(beats == 7));
                beats++;
            end
            prev_stall = cd_valid_o && !cd_ready_i;
            prev_data  = cd_data_o;
        end

        cr_ready_i     = 1'b0;
        cd_ready_i     = 1'b0;
        lookup_gnt_i   = 1'b0;
        lookup_valid_i = 1'b0;
        update_gnt_i   = 1'b0;
        if (aborted) return;

        check({tag, " back to idle"}, 64'(done), 64'd1);
        check({tag, " lookup issued"}, 64'(lk_seen), 64'(!v.exp_unsup));
        if (lk_seen) check({tag, " lookup_addr"}, lk_addr, v.addr & ~64'h3f);
        check({tag, " cr_resp"}, 64'(resp_seen), 64'(v.exp_resp));
        check({tag, " cr accepts"}, 64'(cr_acc), 64'd1);
        check({tag, " cd beats"}, 64'(beats), 64'(v.exp_beats));
        check({tag, " update reqs"}, 64'(upd_cnt), 64'(v.exp_upd));
        if (v.exp_upd) check({tag, " update_inval"}, 64'(inval_seen), 64'(v.exp_inval));
        check({tag, " unsupported pulses"}, 64'(unsup_cnt), 64'(v.exp_unsup));
        check({tag, " cr latency"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        vec_t v;
        // addr, snoop, hit, dirty, shared, base, resp, upd, inval, beats, unsup
        vecs[0]  = '{64'h1000, 4'b0001, 1'b1, 1'b1, 1'b0, 64'hA0, 5'b11101, 1'b1, 1'b0, 8, 1'b0};
        vecs[1]  = '{64'h2040, 4'b0111, 1'b0, 1'b0, 1'b0, 64'h00, 5'b00000, 1'b0, 1'b0, 0, 1'b0};
        vecs[2]  = '{64'h3000, 4'b1001, 1'b1, 1'b0, 1'b1, 64'h30, 5'b00000, 1'b1, 1'b1, 0, 1'b0};
        vecs[3]  = '{64'h0000_1234_5678_9ABF, 4'b0010, 1'b1, 1'b0, 1'b1, 64'h40, 5'b01001,
                     1'b1, 1'b0, 8, 1'b0};
        vecs[4]  = '{64'h5000, 4'b0111, 1'b1, 1'b1, 1'b0, 64'h50, 5'b10101, 1'b1, 1'b1, 8, 1'b0};
        vecs[5]  = '{64'h6010, 4'b1000, 1'b1, 1'b1, 1'b1, 64'h60, 5'b01101, 1'b1, 1'b0, 8, 1'b0};
        vecs[6]  = '{64'h7000, 4'b1000, 1'b1, 1'b0, 1'b0, 64'h70, 5'b11000, 1'b0, 1'b0, 0, 1'b0};
        vecs[7]  = '{64'h8000, 4'b1101, 1'b1, 1'b1, 1'b0, 64'h80, 5'b10000, 1'b1, 1'b1, 0, 1'b0};
        vecs[8]  = '{64'h9000, 4'b1001, 1'b1, 1'b1, 1'b0, 64'h90, 5'b10101, 1'b1, 1'b1, 8, 1'b0};
        vecs[9]  = '{64'hA000, 4'b0011, 1'b1, 1'b1, 1'b1, 64'hB0, 5'b01101, 1'b1, 1'b0, 8, 1'b0};
        vecs[10] = '{64'hB000, 4'b0000, 1'b1, 1'b1, 1'b1, 64'hC0, 5'b01001, 1'b0, 1'b0, 8, 1'b0};
        vecs[11] = '{64'hC000, 4'b0101, 1'b0, 1'b0, 1'b0, 64'h00, 5'b00000, 1'b0, 1'b0, 0, 1'b1};
        vecs[12] = '{64'hD000, 4'b1111, 1'b0, 1'b0, 1'b0, 64'h00, 5'b00000, 1'b0, 1'b0, 0, 1'b1};

        rst_ni          = 1'b0;
        ac_valid_i      = 1'b0;
        ac_addr_i       = '0;
        ac_snoop_i      = '0;
        cr_ready_i      = 1'b0;
        cd_ready_i      = 1'b0;
        lookup_gnt_i    = 1'b0;
        lookup_valid_i  = 1'b0;
        lookup_hit_i    = 1'b0;
        lookup_dirty_i  = 1'b0;
        lookup_shared_i = 1'b0;
        lookup_data_i   = '0;
        update_gnt_i    = 1'b0;

        repeat (2) @(negedge clk_i);
        check_all_zero("reset");
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        for (int i = 0; i < 13; i++) begin
            run_txn($sformatf("v%0d", i), vecs[i], 0, 1'b0, 1'b0, -1);
        end

        // ReadOnce hit, CR stalled 5 cycles, CD ready toggling
        v = '{64'hE000, 4'b0000, 1'b1, 1'b0, 1'b0, 64'hD0, 5'b11001, 1'b0, 1'b0, 8, 1'b0};
        run_txn("stall", v, 5, 1'b1, 1'b0, -1);

        // lookup result in the same cycle as the grant
        v = '{64'hF000, 4'b0111, 1'b1, 1'b0, 1'b0, 64'hE0, 5'b10001, 1'b1, 1'b1, 8, 1'b0};
        run_txn("samecyc", v, 0, 1'b0, 1'b1, -1);

        // reset while CD beat 3 is presented, then a fresh snoop
        run_txn("abort", vecs[0], 0, 1'b0, 1'b0, 3);
        repeat (2) @(negedge clk_i);
        check_all_zero("in reset");
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        v = '{64'h1100, 4'b0001, 1'b1, 1'b0, 1'b1, 64'hF0, 5'b01001, 1'b1, 1'b0, 8, 1'b0};
        run_txn("post_abort", v, 0, 1'b0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
